drift_session_ctrl: RTL and testbench
=====================================

Name: drift_session_ctrl

Overview:
- Registered session sequencer for the drift score device.
- Turns the three front-panel buttons into session state (IDLE / RUN / PAUSE), score counter enable, a one-cycle score clear, and a timed display override (speed or range) that auto-returns to score.
- Sits between the debounced button inputs and the score counter / display mux.

Parameters:
- DISP_HOLD_TICKS, 3000: ticks a speed/range override stays on display before returning to score; minimum 1.
- LONG_PRESS_TICKS, 2000: ticks start_stop must be held to abort the session; minimum 1.
- TICK_CNT_W, 12: width of both tick counters; must hold max(DISP_HOLD_TICKS, LONG_PRESS_TICKS).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_tick  in  1  one-cycle timebase strobe (1 ms nominal)
- i_start_stop  in  1  debounced, synchronised level, active-high
- i_speed_disp  in  1  debounced, synchronised level, active-high
- i_range_disp  in  1  debounced, synchronised level, active-high
- o_cnt_en  out  1  score counter enable; high only in RUN
- o_score_clr  out  1  one-cycle clear pulse to score counter
- o_disp_sel  out  2  00 score, 01 speed, 10 range; 11 never driven
- o_state  out  2  00 IDLE, 01 RUN, 10 PAUSE

Behaviour:
- All outputs registered.
- An input edge first sampled high at clock N is reflected on the outputs after clock N, in cycle N+1.
- Reset (clock with i_rst=1): state IDLE; o_cnt_en=0, o_score_clr=0, o_disp_sel=00, o_state=00; both tick counters cleared.
- Reset also loads the edge-history flops to 1, so a button held through reset produces no edge. It must be released and pressed again.
- Reset mid-session overrides everything in that cycle.
- Edge detect: press = level & ~prev, one per button.

Session state transitions (all on start_stop press):
- IDLE -> RUN, with o_score_clr pulsed for exactly one cycle, coincident with the first RUN cycle.
- RUN -> PAUSE.
- PAUSE -> RUN, with no clear.
- o_cnt_en = (state == RUN), registered together with the state.

Long press:
- While start_stop is held, the long-press counter increments on each i_tick; it is zeroed on release.
- On reaching LONG_PRESS_TICKS in RUN or PAUSE: go to IDLE, pulse o_score_clr once, saturate the counter.
- A saturated counter fires no further action until release.
- Long press in IDLE does nothing beyond its initial press edge. That edge already entered RUN, so the long press then aborts back to IDLE with a clear.

Display override:
- speed press: o_disp_sel=01, hold counter := DISP_HOLD_TICKS.
- range press: o_disp_sel=10, hold counter := DISP_HOLD_TICKS.
- Same-cycle speed and range presses: range wins.
- Hold counter decrements on i_tick while nonzero. On the tick that takes it 1 -> 0, o_disp_sel returns to 00 next cycle.
- A new speed/range press during an override reloads the counter and switches the selection.
- A start_stop press cancels any override: o_disp_sel=00, counter=0, same cycle as the state change.
- Override operates in all states and does not affect o_cnt_en.

Simultaneous events in one cycle:
- start_stop press and speed/range press: state change applies, display goes to 00 (start_stop cancel wins).
- i_tick and press: the press reload wins over the decrement.

Counter width:
- Counters saturate and never wrap.
- Parameters exceeding 2^TICK_CNT_W-1 are illegal; simulation assertion.

Decomposition:
- Package drift_pkg:
  - DISP_SCORE=2'b00, DISP_SPEED=2'b01, DISP_RANGE=2'b10
  - ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10
- Sub-module btn_edge: a one-flop edge detector with reset value 1, instantiated three times.
- Tick counters and FSM stay inline.

Test Plan (bench params DISP_HOLD_TICKS=4, LONG_PRESS_TICKS=3, i_tick every 10 clocks):
- Reset then start_stop pulse of 2 clocks -> next cycle o_state=01, o_cnt_en=1, o_score_clr=1 for exactly 1 cycle.
- Two more separate start_stop presses -> PAUSE (o_cnt_en=0, no clear), then RUN (o_cnt_en=1, no clear).
- In RUN, hold start_stop through 3 ticks -> after 3rd tick o_state=00, o_cnt_en=0, one o_score_clr pulse; keep holding 5 more ticks -> no further pulse.
- speed press -> o_disp_sel=01; after exactly 4 ticks -> 00. Range press at tick 2 of a speed override -> 10, held a full 4 ticks from reload.
- speed and range press in same cycle -> 10. Then start_stop press -> o_disp_sel=00 immediately and state advances.
- Hold range_disp high across reset release -> no override until release and re-press; assert i_rst mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/drift_pkg.sv
// rtl/drift_pkg.sv - shared encodings for the drift score session sequencer
package drift_pkg;

    localparam logic [1:0] DISP_SCORE = 2'b00;
    localparam logic [1:0] DISP_SPEED = 2'b01;
    localparam logic [1:0] DISP_RANGE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } session_state_t;

endpackage

// File: rtl/drift_session_ctrl_if.sv
// rtl/drift_session_ctrl_if.sv - button inputs and session outputs of the sequencer
interface drift_session_ctrl_if;
    logic       i_tick;
    logic       i_start_stop;
    logic       i_speed_disp;
    logic       i_range_disp;
    logic       o_cnt_en;
    logic       o_score_clr;
    logic [1:0] o_disp_sel;
    logic [1:0] o_state;

    modport master (
        output i_tick, i_start_stop, i_speed_disp, i_range_disp,
        input  o_cnt_en, o_score_clr, o_disp_sel, o_state
    );

    modport slave (
        input  i_tick, i_start_stop, i_speed_disp, i_range_disp,
        output o_cnt_en, o_score_clr, o_disp_sel, o_state
    );
endinterface

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - rising-edge detector for one debounced button level
// History resets to 1 so a button held through reset never yields a press.
module btn_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic level,
    output logic press
);

    logic prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign press = level & ~prev;

endmodule

// File: rtl/drift_session_ctrl.sv
// rtl/drift_session_ctrl.sv - session FSM, long-press abort and timed display override
module drift_session_ctrl
    import drift_pkg::*;
#(
    parameter int unsigned DISP_HOLD_TICKS  = 3000,
    parameter int unsigned LONG_PRESS_TICKS = 2000,
    parameter int unsigned TICK_CNT_W       = 12
) (
    input  logic i_clk,
    input  logic i_rst,
    drift_session_ctrl_if.slave bus
);

    localparam int unsigned CNT_MAX = (1 << TICK_CNT_W) - 1;
    localparam bit PARAMS_OK = (DISP_HOLD_TICKS >= 1) && (LONG_PRESS_TICKS >= 1) &&
                               (DISP_HOLD_TICKS <= CNT_MAX) && (LONG_PRESS_TICKS <= CNT_MAX);

    localparam logic [TICK_CNT_W-1:0] HOLD_LOAD = TICK_CNT_W'(DISP_HOLD_TICKS);
    localparam logic [TICK_CNT_W-1:0] LP_SAT    = TICK_CNT_W'(LONG_PRESS_TICKS);
    localparam logic [TICK_CNT_W-1:0] LP_LAST   = TICK_CNT_W'(LONG_PRESS_TICKS - 1);
    localparam logic [TICK_CNT_W-1:0] CNT_ONE   = TICK_CNT_W'(1);

    session_state_t        state;
    logic [TICK_CNT_W-1:0] lp_cnt;
    logic [TICK_CNT_W-1:0] hold_cnt;
    logic                  cnt_en;
    logic                  score_clr;
    logic [1:0]            disp_sel;

    logic ss_press;
    logic speed_press;
    logic range_press;
    logic lp_fire;

    btn_edge u_edge_ss (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .level (bus.i_start_stop),
        .press (ss_press)
    );

    btn_edge u_edge_speed (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .level (bus.i_speed_disp),
        .press (speed_press)
    );

    btn_edge u_edge_range (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .level (bus.i_range_disp),
        .press (range_press)
    );

    // Fires only on the tick that brings the held count up to the threshold;
    // once saturated the compare no longer matches until release.
    assign lp_fire = bus.i_start_stop && bus.i_tick && (lp_cnt == LP_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cnt_en    <= 1'b0;
            score_clr <= 1'b0;
            disp_sel  <= DISP_SCORE;
            lp_cnt    <= '0;
            hold_cnt  <= '0;
        end else begin
            score_clr <= 1'b0;

            if (!bus.i_start_stop) begin
                lp_cnt <= '0;
            end else if (bus.i_tick && (lp_cnt != LP_SAT)) begin
                lp_cnt <= lp_cnt + CNT_ONE;
            end

            if (lp_fire && (state != ST_IDLE)) begin
                state     <= ST_IDLE;
                cnt_en    <= 1'b0;
                score_clr <= 1'b1;
            end else if (ss_press) begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_RUN;
                        cnt_en    <= 1'b1;
                        score_clr <= 1'b1;
                    end
                    ST_RUN: begin
                        state  <= ST_PAUSE;
                        cnt_en <= 1'b0;
                    end
                    default: begin
                        state  <= ST_RUN;
                        cnt_en <= 1'b1;
                    end
                endcase
            end

            // start_stop cancel beats a display press; a press reload beats a tick.
            if (ss_press) begin
                disp_sel <= DISP_SCORE;
                hold_cnt <= '0;
            end else if (range_press) begin
                disp_sel <= DISP_RANGE;
                hold_cnt <= HOLD_LOAD;
            end else if (speed_press) begin
                disp_sel <= DISP_SPEED;
                hold_cnt <= HOLD_LOAD;
            end else if (bus.i_tick && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - CNT_ONE;
                if (hold_cnt == CNT_ONE) begin
                    disp_sel <= DISP_SCORE;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            assert (PARAMS_OK)
            else $error("drift_session_ctrl: tick parameters out of range for TICK_CNT_W");
        end
    end

    assign bus.o_state     = state;
    assign bus.o_cnt_en    = cnt_en;
    assign bus.o_score_clr = score_clr;
    assign bus.o_disp_sel  = disp_sel;

endmodule

// File: tb/tb_drift_session_ctrl.sv
// tb/tb_drift_session_ctrl.sv - randomized and directed check of drift_session_ctrl against a behavioural model
module tb_drift_session_ctrl;

    localparam int HOLD = 4;
    localparam int LONG = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    drift_session_ctrl_if bus ();

    drift_session_ctrl #(
        .DISP_HOLD_TICKS  (HOLD),
        .LONG_PRESS_TICKS (LONG),
        .TICK_CNT_W       (12)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int ticks_seen = 0;

    // Behavioural model: session as a small integer, button history, ticks held, ticks left on display
    int m_state = 0;
    int m_clr = 0;
    int m_sel = 0;
    int m_remain = 0;
    int m_held_ticks = 0;
    bit m_prev_ss = 1, m_prev_sp = 1, m_prev_rg = 1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step(input bit r, input bit tk, input bit ss, input bit sp, input bit rg);
        bit ss_p, sp_p, rg_p, abort;
        if (r) begin
            m_state = 0; m_clr = 0; m_sel = 0; m_remain = 0; m_held_ticks = 0;
            m_prev_ss = 1; m_prev_sp = 1; m_prev_rg = 1;
            return;
        end
        ss_p = ss && !m_prev_ss;
        sp_p = sp && !m_prev_sp;
        rg_p = rg && !m_prev_rg;
        m_prev_ss = ss; m_prev_sp = sp; m_prev_rg = rg;

        abort = 0;
        if (!ss) m_held_ticks = 0;
        else if (tk) begin
            m_held_ticks++;
            abort = (m_held_ticks == LONG);
        end

        m_clr = 0;
        if (abort && m_state != 0) begin
            m_state = 0;
            m_clr = 1;
        end else if (ss_p) begin
            if (m_state == 0) m_clr = 1;
            m_state = (m_state == 1) ? 2 : 1;
        end

        if (ss_p) begin
            m_sel = 0; m_remain = 0;
        end else if (rg_p || sp_p) begin
            m_sel = rg_p ? 2 : 1;
            m_remain = HOLD;
        end else if (tk && m_remain > 0) begin
            m_remain--;
            if (m_remain == 0) m_sel = 0;
        end
    endtask

    task automatic step();
        bit tk;
        tk = bus.i_tick;
        @(posedge clk);
        model_step(rst, tk, bus.i_start_stop, bus.i_speed_disp, bus.i_range_disp);
        if (tk) ticks_seen++;
        @(negedge clk);
        check("state", bus.o_state, m_state);
        check("cnt_en", bus.o_cnt_en, (m_state == 1) ? 1 : 0);
        check("score_clr", bus.o_score_clr, m_clr);
        check("disp_sel", bus.o_disp_sel, m_sel);
        cyc++;
        bus.i_tick = (cyc % 10 == 9);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_ticks(input int k);
        int t0, guard;
        t0 = ticks_seen;
        guard = 0;
        while ((ticks_seen - t0) < k && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) check("tick_timeout", 1, 0);
    endtask

    initial begin
        int t0, pulses;
        bus.i_tick = 0;
        bus.i_start_stop = 0;
        bus.i_speed_disp = 0;
        bus.i_range_disp = 0;

        rst = 1; run(2);
        check("rst_state", bus.o_state, 0);
        check("rst_cnt_en", bus.o_cnt_en, 0);
        check("rst_clr", bus.o_score_clr, 0);
        check("rst_sel", bus.o_disp_sel, 0);
        rst = 0; run(2);

        bus.i_start_stop = 1; step();
        check("start_state", bus.o_state, 1);
        check("start_en", bus.o_cnt_en, 1);
        check("start_clr", bus.o_score_clr, 1);
        step();
        check("start_clr_once", bus.o_score_clr, 0);
        bus.i_start_stop = 0; run(3);

        bus.i_start_stop = 1; step();
        check("pause_state", bus.o_state, 2);
        check("pause_en", bus.o_cnt_en, 0);
        check("pause_clr", bus.o_score_clr, 0);
        bus.i_start_stop = 0; run(3);

        t0 = ticks_seen;
        bus.i_start_stop = 1; step();
        check("resume_state", bus.o_state, 1);
        check("resume_clr", bus.o_score_clr, 0);
        while ((ticks_seen - t0) < LONG) step();
        check("long_state", bus.o_state, 0);
        check("long_en", bus.o_cnt_en, 0);
        check("long_clr", bus.o_score_clr, 1);
        t0 = ticks_seen;
        pulses = 0;
        while ((ticks_seen - t0) < 5) begin
            step();
            if (bus.o_score_clr) pulses++;
        end
        check("long_no_repulse", pulses, 0);
        check("long_still_idle", bus.o_state, 0);
        bus.i_start_stop = 0; run(2);

        bus.i_speed_disp = 1; step();
        check("speed_sel", bus.o_disp_sel, 1);
        bus.i_speed_disp = 0;
        wait_ticks(HOLD - 1);
        check("speed_held", bus.o_disp_sel, 1);
        wait_ticks(1);
        check("speed_expire", bus.o_disp_sel, 0);

        bus.i_speed_disp = 1; step();
        bus.i_speed_disp = 0;
        wait_ticks(2);
        bus.i_range_disp = 1; step();
        check("range_switch", bus.o_disp_sel, 2);
        bus.i_range_disp = 0;
        wait_ticks(HOLD - 1);
        check("range_held", bus.o_disp_sel, 2);
        wait_ticks(1);
        check("range_expire", bus.o_disp_sel, 0);

        bus.i_speed_disp = 1; bus.i_range_disp = 1; step();
        check("both_range_wins", bus.o_disp_sel, 2);
        bus.i_speed_disp = 0; bus.i_range_disp = 0; step();
        bus.i_start_stop = 1; step();
        check("ss_cancel_sel", bus.o_disp_sel, 0);
        check("ss_cancel_state", bus.o_state, 1);
        bus.i_start_stop = 0; run(2);

        bus.i_range_disp = 1; rst = 1; run(2);
        rst = 0; run(3);
        check("held_through_rst", bus.o_disp_sel, 0);
        bus.i_range_disp = 0; step();
        bus.i_range_disp = 1; step();
        check("repress_after_rst", bus.o_disp_sel, 2);
        bus.i_range_disp = 0; step();

        bus.i_start_stop = 1; step();
        bus.i_start_stop = 0; run(2);
        rst = 1; step();
        check("midrun_rst_state", bus.o_state, 0);
        check("midrun_rst_en", bus.o_cnt_en, 0);
        check("midrun_rst_sel", bus.o_disp_sel, 0);
        rst = 0; step();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 23) == 0) bus.i_start_stop = ~bus.i_start_stop;
            if ($urandom_range(0, 23) == 0) bus.i_speed_disp = ~bus.i_speed_disp;
            if ($urandom_range(0, 23) == 0) bus.i_range_disp = ~bus.i_range_disp;
            rst = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
